// File: rtl/rcc_vdd_pkg.sv
// Shared types and constants for the VDD-domain RCC write sequencer.
// Holds the FSM states, the requester indices and the index/one-hot helpers.
package rcc_vdd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WRITE  = 3'd2,
    HOLD   = 3'd3,
    VERIFY = 3'd4,
    ACK    = 3'd5
  } state_e;

  localparam logic [1:0] C1_RMVF = 2'd0;
  localparam logic [1:0] C2_RMVF = 2'd1;
  localparam logic [1:0] LSION   = 2'd2;

  localparam int unsigned WR_HOLD_DEF     = 2;
  localparam int unsigned VFY_TIMEOUT_DEF = 8;

  // Round-robin successor over the three requesters (2 wraps to 0).
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == LSION) ? C1_RMVF : idx + 2'd1;
  endfunction

  function automatic logic [2:0] idx2oh(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = C1_RMVF;
    if (oh[C2_RMVF]) idx = C2_RMVF;
    if (oh[LSION])   idx = LSION;
    return idx;
  endfunction

endpackage

// File: rtl/rcc_vdd_wr_seq_if.sv
// Requester and register-bank signals of the VDD write sequencer.
// The sequencer takes the slave side; the requesters and register bank drive the master side.
interface rcc_vdd_wr_seq_if;

  logic [2:0] req;
  logic [2:0] req_wdata;
  logic [2:0] ack;
  logic [2:0] err;
  logic       busy;
  logic       rcc_vdd_wdata;
  logic       raw_rcc_c1_rsr_rmvf_wren;
  logic       raw_rcc_c2_rsr_rmvf_wren;
  logic       raw_rcc_csr_lsion_wren;
  logic       cur_rcc_c1_rsr_rmvf;
  logic       cur_rcc_c2_rsr_rmvf;
  logic       cur_rcc_csr_lsion;

  modport master (
    output req, req_wdata,
    output cur_rcc_c1_rsr_rmvf, cur_rcc_c2_rsr_rmvf, cur_rcc_csr_lsion,
    input  ack, err, busy, rcc_vdd_wdata,
    input  raw_rcc_c1_rsr_rmvf_wren, raw_rcc_c2_rsr_rmvf_wren, raw_rcc_csr_lsion_wren
  );

  modport slave (
    input  req, req_wdata,
    input  cur_rcc_c1_rsr_rmvf, cur_rcc_c2_rsr_rmvf, cur_rcc_csr_lsion,
    output ack, err, busy, rcc_vdd_wdata,
    output raw_rcc_c1_rsr_rmvf_wren, raw_rcc_c2_rsr_rmvf_wren, raw_rcc_csr_lsion_wren
  );

endinterface

// File: rtl/rcc_vdd_rr_arb.sv
// Three-way round-robin arbiter; the pointer names the highest-priority requester
// and moves past the finished requester when advance_i is pulsed.
module rcc_vdd_rr_arb
  import rcc_vdd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       advance_i,
  input  logic [1:0] last_idx_i,
  output logic [2:0] grant_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand0, cand1, cand2;

  assign cand0 = ptr_q;
  assign cand1 = rr_next(cand0);
  assign cand2 = rr_next(cand1);

  always_comb begin
    grant_o = 3'b000;
    if (req_i[cand0])      grant_o = idx2oh(cand0);
    else if (req_i[cand1]) grant_o = idx2oh(cand1);
    else if (req_i[cand2]) grant_o = idx2oh(cand2);
  end

  assign ptr_d = advance_i ? rr_next(last_idx_i) : ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= C1_RMVF;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rcc_vdd_wr_seq.sv
// Serialises three requesters' single-bit writes into the VDD register bank:
// setup, strobe for WR_HOLD cycles, hold, read back with timeout, then acknowledge.
module rcc_vdd_wr_seq
  import rcc_vdd_pkg::*;
#(
  parameter int unsigned WR_HOLD     = WR_HOLD_DEF,
  parameter int unsigned VFY_TIMEOUT = VFY_TIMEOUT_DEF
) (
  input logic             lsi_clk,
  input logic             rst_n,
  rcc_vdd_wr_seq_if.slave bus
);

  localparam logic [3:0] WR_LAST  = 4'(WR_HOLD - 1);
  localparam logic [3:0] VFY_LAST = 4'(VFY_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gidx_q, gidx_d;
  logic       wdata_q, wdata_d;
  logic       err_q, err_d;
  logic       advance;
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic [2:0] cur;
  logic [2:0] grant_oh;
  logic [2:0] wren;

  rcc_vdd_rr_arb u_arb (
    .clk_i      (lsi_clk),
    .rst_ni     (rst_n),
    .req_i      (bus.req),
    .advance_i  (advance),
    .last_idx_i (gidx_q),
    .grant_o    (grant)
  );

  assign grant_idx = oh2idx(grant);
  assign cur = {bus.cur_rcc_csr_lsion, bus.cur_rcc_c2_rsr_rmvf, bus.cur_rcc_c1_rsr_rmvf};

  // Requests are only looked at in IDLE, so anything arriving mid-transfer simply waits.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (|bus.req) begin
          gidx_d  = grant_idx;
          wdata_d = bus.req_wdata[grant_idx];
          state_d = SETUP;
        end
      end
      SETUP:  state_d = WRITE;
      WRITE:  if (cnt_q == WR_LAST) state_d = HOLD;
      HOLD:   state_d = VERIFY;
      VERIFY: begin
        if (cur[gidx_q] == wdata_q) begin
          state_d = ACK;
        end else if (cnt_q == VFY_LAST) begin
          state_d = ACK;
          err_d   = 1'b1;
        end
      end
      ACK: begin
        advance = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cleared on every state change and saturating, so long timeouts never alias.
  assign cnt_d = (state_d != state_q) ? 4'd0 :
                 (cnt_q == 4'hF)      ? cnt_q : cnt_q + 4'd1;

  always_ff @(posedge lsi_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gidx_q  <= C1_RMVF;
      wdata_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gidx_q  <= gidx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign grant_oh = idx2oh(gidx_q);
  assign wren     = (state_q == WRITE) ? grant_oh : 3'b000;

  assign bus.busy                     = (state_q != IDLE);
  assign bus.rcc_vdd_wdata            = (state_q inside {SETUP, WRITE, HOLD, VERIFY}) ? wdata_q : 1'b0;
  assign bus.raw_rcc_c1_rsr_rmvf_wren = wren[C1_RMVF];
  assign bus.raw_rcc_c2_rsr_rmvf_wren = wren[C2_RMVF];
  assign bus.raw_rcc_csr_lsion_wren   = wren[LSION];
  assign bus.ack                      = (state_q == ACK) ? grant_oh : 3'b000;
  assign bus.err                      = (state_q == ACK && err_q) ? grant_oh : 3'b000;

endmodule

// File: tb/tb_rcc_vdd_wr_seq.sv
// Directed, table-driven bench for rcc_vdd_wr_seq at the default WR_HOLD=2, VFY_TIMEOUT=8.
// Each table row is one clock cycle: inputs for that cycle and the outputs expected in it.
module tb_rcc_vdd_wr_seq;

  typedef struct {
    logic       rstN;
    logic [2:0] req;
    logic [2:0] wdata;
    logic [2:0] cur;
    logic [2:0] expAck;
    logic [2:0] expErr;
    logic       expBusy;
    logic       expWd;
    logic [2:0] expWren;
  } vec_t;

  vec_t vecs[$];
  logic lsi_clk = 1'b0;
  logic rst_n;
  int   passCount    = 0;
  int   checkCount   = 0;
  int   overlapCount = 0;
  bit   monitorOn    = 1'b0;

  rcc_vdd_wr_seq_if bus ();

  rcc_vdd_wr_seq #(
    .WR_HOLD     (2),
    .VFY_TIMEOUT (8)
  ) dut (
    .lsi_clk (lsi_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 lsi_clk = ~lsi_clk;

  // Write strobes must be mutually exclusive in every cycle after reset.
  always @(negedge lsi_clk) begin
    if (monitorOn && ($countones({bus.raw_rcc_csr_lsion_wren, bus.raw_rcc_c2_rsr_rmvf_wren,
                                  bus.raw_rcc_c1_rsr_rmvf_wren}) > 1))
      overlapCount++;
  end

  function automatic void addVec(input logic r, input logic [2:0] rq, input logic [2:0] wd,
                                 input logic [2:0] cu, input logic [2:0] ack, input logic [2:0] err,
                                 input logic busy, input logic wdo, input logic [2:0] wren);
    vec_t v;
    v.rstN = r; v.req = rq; v.wdata = wd; v.cur = cu;
    v.expAck = ack; v.expErr = err; v.expBusy = busy; v.expWd = wdo; v.expWren = wren;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n         = v.rstN;
    bus.req       = v.req;
    bus.req_wdata = v.wdata;
    {bus.cur_rcc_csr_lsion, bus.cur_rcc_c2_rsr_rmvf, bus.cur_rcc_c1_rsr_rmvf} = v.cur;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [10:0] dutOutputs();
    return {bus.ack, bus.err, bus.busy, bus.rcc_vdd_wdata, bus.raw_rcc_csr_lsion_wren,
            bus.raw_rcc_c2_rsr_rmvf_wren, bus.raw_rcc_c1_rsr_rmvf_wren};
  endfunction

  function automatic logic [10:0] expOutputs(input vec_t v);
    return {v.expAck, v.expErr, v.expBusy, v.expWd, v.expWren};
  endfunction

  task automatic fillVectors();
    // reset state
    addVec(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // c1 write of 1, readback rises during WRITE: ack at cycle 6
    addVec(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // reset after the first WRITE cycle aborts; pointer back to index 0
    addVec(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // all three requesting out of reset: grants 0,1,2 with acks at 6, 13, 20
    addVec(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b111, 3'b111, 3'b111, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b010);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b010);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b110, 3'b111, 3'b111, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b100);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b100);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b100, 3'b111, 3'b111, 3'b100, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // lsion readback stuck at 0, req dropped after SETUP: ack+err at cycle 13
    addVec(1'b1, 3'b100, 3'b100, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b100, 3'b100, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b100);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b100);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 8; i++)
      addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // one-cycle req[1] pulse while busy on index 0 is withdrawn
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001);
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001);
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b010, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    // req[1] raised on the ACK cycle is granted in the following IDLE cycle
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001);
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b010);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b010);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
    addVec(1'b1, 3'b010, 3'b011, 3'b011, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000);
    addVec(1'b1, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
  endtask

  // Readback matches only in the last allowed VERIFY cycle (cycle 12): ack at 13 without err.
  task automatic lateMatchSequence();
    int         cyc;
    int         ackCyc;
    logic [2:0] ackSeen;
    logic [2:0] errSeen;
    cyc     = 0;
    ackCyc  = -1;
    ackSeen = 3'bxxx;
    errSeen = 3'bxxx;
    rst_n         = 1'b1;
    bus.req       = 3'b100;
    bus.req_wdata = 3'b100;
    {bus.cur_rcc_csr_lsion, bus.cur_rcc_c2_rsr_rmvf, bus.cur_rcc_c1_rsr_rmvf} = 3'b000;
    while (cyc < 30 && ackCyc < 0) begin
      @(posedge lsi_clk);
      #1;
      cyc++;
      if (cyc == 2)  bus.req = 3'b000;
      if (cyc == 12) bus.cur_rcc_csr_lsion = 1'b1;
      if (bus.ack !== 3'b000) begin
        ackCyc  = cyc;
        ackSeen = bus.ack;
        errSeen = bus.err;
      end
    end
    checkOutput("late_match_ack_cycle", 32'(ackCyc), 32'd13);
    checkOutput("late_match_ack", {29'd0, ackSeen}, {29'd0, 3'b100});
    checkOutput("late_match_err", {29'd0, errSeen}, {29'd0, 3'b000});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req       = 3'b000;
    bus.req_wdata = 3'b000;
    {bus.cur_rcc_csr_lsion, bus.cur_rcc_c2_rsr_rmvf, bus.cur_rcc_c1_rsr_rmvf} = 3'b000;
    fillVectors();
    repeat (2) @(posedge lsi_clk);
    #1;
    monitorOn = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge lsi_clk);
      checkOutput($sformatf("vec%0d", i), {21'd0, dutOutputs()}, {21'd0, expOutputs(vecs[i])});
      @(posedge lsi_clk);
      #1;
    end
    lateMatchSequence();
    checkOutput("wren_overlap_count", 32'(overlapCount), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
